// File: rtl/memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_bus_arbiter
// Purpose  : Shares the single test-memory port between the debug controller
//            and the core under test. The controller always has access. The
//            core competes only while mux_selector=1. Ties are broken
//            round-robin. Core addresses are relocated by the active memory
//            page. Every memory strobe is bounded by a timeout.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            mux_selector          - 0: controller only, 1: shared bus
//            page_number           - page added to core addresses at grant
//            ctrl_* / core_*       - requester side (level request, pulse resp)
//            mem_*                 - memory side (held strobe, pulse response)
//            owner                 - 0: controller granted, 1: core granted
//            busy                  - 1 whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module memory_bus_arbiter #(
  parameter int BUS_WIDTH      = 32,
  parameter int PAGE_SHIFT     = 24,
  parameter int TIMEOUT_CYCLES = 360
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mux_selector,
  input  logic [7:0]           page_number,
  // controller requester
  input  logic                 ctrl_read,
  input  logic                 ctrl_write,
  input  logic [BUS_WIDTH-1:0] ctrl_address,
  input  logic [BUS_WIDTH-1:0] ctrl_write_data,
  output logic [BUS_WIDTH-1:0] ctrl_read_data,
  output logic                 ctrl_response,
  output logic                 ctrl_error,
  // core requester
  input  logic                 core_read,
  input  logic                 core_write,
  input  logic [BUS_WIDTH-1:0] core_address,
  input  logic [BUS_WIDTH-1:0] core_write_data,
  output logic [BUS_WIDTH-1:0] core_read_data,
  output logic                 core_response,
  output logic                 core_error,
  // memory port
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [BUS_WIDTH-1:0] mem_address,
  output logic [BUS_WIDTH-1:0] mem_write_data,
  input  logic [BUS_WIDTH-1:0] mem_read_data,
  input  logic                 mem_response,
  // status
  output logic                 owner,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_CTRL_ACCESS = 2'd1;
  localparam logic [1:0] S_CORE_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE        = 2'd3;

  // The counter starts at 0 in the first strobe cycle, so reaching this value
  // means the strobe has been high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state;
  logic [1:0]           next_state;
  logic                 last_grant;     // 1 = core won the most recent tie
  logic                 is_write;       // latched operation of the granted request
  logic [15:0]          timeout_count;

  logic                 ctrl_eligible;
  logic                 core_eligible;
  logic                 tie;
  logic                 grant_valid;
  logic                 grant_core;
  logic                 in_access;
  logic                 timed_out;
  logic                 access_done;
  logic [BUS_WIDTH-1:0] page_offset;
  logic [BUS_WIDTH-1:0] core_mem_address;

  // --------------------------------------------------------------------------
  // Arbitration and completion decode
  // --------------------------------------------------------------------------
  assign ctrl_eligible = ctrl_read | ctrl_write;
  assign core_eligible = mux_selector & (core_read | core_write);
  assign tie           = ctrl_eligible & core_eligible;
  assign grant_valid   = ctrl_eligible | core_eligible;
  // On a tie the requester that did not win the previous tie goes first.
  assign grant_core    = core_eligible & (~ctrl_eligible | ~last_grant);

  assign in_access   = (state == S_CTRL_ACCESS) || (state == S_CORE_ACCESS);
  // A response arriving in the final counted cycle still wins over timeout.
  assign timed_out   = in_access && !mem_response && (timeout_count == TIMEOUT_LAST);
  assign access_done = in_access && (mem_response || timed_out);

  // Page relocation; the carry out of the top bit is deliberately dropped.
  assign page_offset      = BUS_WIDTH'(page_number) << PAGE_SHIFT;
  assign core_mem_address = core_address + page_offset;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (grant_valid) begin
          next_state = grant_core ? S_CORE_ACCESS : S_CTRL_ACCESS;
        end
      end
      S_CTRL_ACCESS,
      S_CORE_ACCESS: begin
        if (access_done) begin
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs decoded from state. Strobes drop in the same edge that moves
  // the FSM to DONE, and a reset edge returns to IDLE, so no response or
  // strobe can leak out of an aborted transaction.
  // --------------------------------------------------------------------------
  always_comb begin
    busy          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ctrl_response = 1'b0;
    core_response = 1'b0;
    case (state)
      S_CTRL_ACCESS,
      S_CORE_ACCESS: begin
        busy      = 1'b1;
        mem_read  = ~is_write;
        mem_write = is_write;
      end
      S_DONE: begin
        busy          = 1'b1;
        ctrl_response = ~owner;
        core_response = owner;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: request latching at grant, timeout counting and result capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant     <= 1'b1;   // controller wins the first tie
      owner          <= 1'b0;
      is_write       <= 1'b0;
      timeout_count  <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      ctrl_read_data <= '0;
      ctrl_error     <= 1'b0;
      core_read_data <= '0;
      core_error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          timeout_count <= '0;
          if (grant_valid) begin
            owner <= grant_core;
            if (tie) begin
              last_grant <= grant_core;
            end
            // Write takes precedence when both strobes are high.
            if (grant_core) begin
              is_write       <= core_write;
              mem_address    <= core_mem_address;
              mem_write_data <= core_write_data;
            end else begin
              is_write       <= ctrl_write;
              mem_address    <= ctrl_address;
              mem_write_data <= ctrl_write_data;
            end
          end
        end
        S_CTRL_ACCESS,
        S_CORE_ACCESS: begin
          if (access_done) begin
            timeout_count <= '0;
            if (owner) begin
              core_read_data <= mem_response ? mem_read_data : '0;
              core_error     <= ~mem_response;
            end else begin
              ctrl_read_data <= mem_response ? mem_read_data : '0;
              ctrl_error     <= ~mem_response;
            end
          end else begin
            timeout_count <= timeout_count + 16'd1;
          end
        end
        default: begin
          timeout_count <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_bus_arbiter
// Purpose  : Self-checking bench for memory_bus_arbiter. A transaction-level
//            reference model predicts the winner, relocated address, strobe
//            length, response, error and read data of every access.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_bus_arbiter;

  localparam int T = 8;   // timeout used for this bench

  logic        clk = 1'b0;
  logic        reset;
  logic        mux_selector;
  logic [7:0]  page_number;
  logic        ctrl_read, ctrl_write;
  logic [31:0] ctrl_address, ctrl_write_data, ctrl_read_data;
  logic        ctrl_response, ctrl_error;
  logic        core_read, core_write;
  logic [31:0] core_address, core_write_data, core_read_data;
  logic        core_response, core_error;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_response;
  logic        owner, busy;

  int          checks = 0;
  int          errors = 0;
  bit          m_last_core;   // model: 1 = core won the most recent tie
  logic [1:0]  rw;

  always #5 clk = ~clk;

  memory_bus_arbiter #(
    .BUS_WIDTH(32),
    .PAGE_SHIFT(24),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mux_selector(mux_selector),
    .page_number(page_number),
    .ctrl_read(ctrl_read),
    .ctrl_write(ctrl_write),
    .ctrl_address(ctrl_address),
    .ctrl_write_data(ctrl_write_data),
    .ctrl_read_data(ctrl_read_data),
    .ctrl_response(ctrl_response),
    .ctrl_error(ctrl_error),
    .core_read(core_read),
    .core_write(core_write),
    .core_address(core_address),
    .core_write_data(core_write_data),
    .core_read_data(core_read_data),
    .core_response(core_response),
    .core_error(core_error),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .mem_response(mem_response),
    .owner(owner),
    .busy(busy)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // No eligible requester: the arbiter must stay idle.
  task automatic idle_check(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick();
      check_value("stall_idle", {27'd0, busy, mem_read, mem_write, ctrl_response, core_response}, 32'd0);
    end
  endtask

  // One complete transaction starting from IDLE with the current request
  // levels. The memory answers in strobe cycle dly (dly >= T: never).
  task automatic do_txn(input int dly, input bit drop_mux, input bit late, input logic [31:0] rd_val);
    bit          ce, ke, win_core, exp_wr, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    int          n, exp_len;

    ce = ctrl_read | ctrl_write;
    ke = mux_selector & (core_read | core_write);
    if (ce && ke) begin
      win_core    = !m_last_core;
      m_last_core = win_core;
    end else begin
      win_core = ke;
    end
    exp_wr    = win_core ? core_write : ctrl_write;
    exp_addr  = win_core ? core_address + ({24'd0, page_number} << 24) : ctrl_address;
    exp_wdata = win_core ? core_write_data : ctrl_write_data;
    exp_err   = (dly >= T);
    exp_len   = exp_err ? T : dly + 1;
    exp_rdata = exp_err ? 32'd0 : rd_val;

    tick();   // grant edge
    check_value("busy_access", {31'd0, busy}, 32'd1);
    check_value("owner", {31'd0, owner}, {31'd0, win_core});
    check_value("strobe_kind", {30'd0, mem_write, mem_read}, exp_wr ? 32'd2 : 32'd1);
    check_value("mem_address", mem_address, exp_addr);
    if (exp_wr) check_value("mem_write_data", mem_write_data, exp_wdata);

    n = 0;
    while ((mem_read || mem_write) && n < T + 4) begin
      check_value("resp_in_access", {30'd0, ctrl_response, core_response}, 32'd0);
      if (drop_mux && n == 0) mux_selector = 1'b0;
      page_number = 8'($urandom);   // must not disturb a granted access
      if (n == dly) begin
        mem_read_data = rd_val;
        mem_response  = 1'b1;
      end
      n++;
      tick();
      mem_response  = 1'b0;
      mem_read_data = $urandom;
    end
    check_value("strobe_cycles", n, exp_len);

    check_value("busy_done", {31'd0, busy}, 32'd1);
    if (win_core) begin
      check_value("core_response", {31'd0, core_response}, 32'd1);
      check_value("ctrl_resp_quiet", {31'd0, ctrl_response}, 32'd0);
      check_value("core_error", {31'd0, core_error}, {31'd0, exp_err});
      check_value("core_read_data", core_read_data, exp_rdata);
      core_read  = 1'b0;
      core_write = 1'b0;
    end else begin
      check_value("ctrl_response", {31'd0, ctrl_response}, 32'd1);
      check_value("core_resp_quiet", {31'd0, core_response}, 32'd0);
      check_value("ctrl_error", {31'd0, ctrl_error}, {31'd0, exp_err});
      check_value("ctrl_read_data", ctrl_read_data, exp_rdata);
      ctrl_read  = 1'b0;
      ctrl_write = 1'b0;
    end
    if (late) mem_response = 1'b1;   // stray response outside ACCESS
    tick();
    mem_response = 1'b0;
    check_value("idle_after_done", {27'd0, busy, mem_read, mem_write, ctrl_response, core_response}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mux_selector = 1'b0; page_number = 8'd0;
    ctrl_read = 1'b0; ctrl_write = 1'b0; ctrl_address = '0; ctrl_write_data = '0;
    core_read = 1'b0; core_write = 1'b0; core_address = '0; core_write_data = '0;
    mem_read_data = '0; mem_response = 1'b0;
    m_last_core = 1'b1;
    tick(); tick();
    check_value("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check_value("rst_resp", {28'd0, ctrl_response, core_response, ctrl_error, core_error}, 32'd0);
    check_value("rst_status", {30'd0, owner, busy}, 32'd0);
    check_value("rst_mem_address", mem_address, 32'd0);
    check_value("rst_mem_wdata", mem_write_data, 32'd0);
    check_value("rst_ctrl_rdata", ctrl_read_data, 32'd0);
    check_value("rst_core_rdata", core_read_data, 32'd0);
    reset = 1'b0;

    // Controller write while core_write waits on a controller-only bus.
    ctrl_write = 1'b1; ctrl_address = 32'h10; ctrl_write_data = 32'hCAFEBABE;
    core_write = 1'b1; core_address = 32'h99; core_write_data = 32'h5555AAAA;
    do_txn(1, 1'b0, 1'b0, $urandom);
    idle_check(2);
    core_write = 1'b0;

    // Core read relocated by page 0x02.
    mux_selector = 1'b1; page_number = 8'h02;
    core_read = 1'b1; core_address = 32'h40;
    do_txn(0, 1'b0, 1'b0, 32'h12345678);

    // Both request continuously: ties alternate ctrl, core, ...
    ctrl_read = 1'b1; ctrl_address = $urandom;
    core_write = 1'b1; core_address = $urandom; core_write_data = $urandom;
    for (int i = 0; i < 6; i++) begin
      do_txn($urandom_range(0, 2), 1'b0, 1'b0, $urandom);
      check_value("alternating_owner", {31'd0, owner}, i % 2);
      if (i < 5) begin
        if (i % 2 == 0) begin ctrl_read = 1'b1; ctrl_address = $urandom; end
        else begin core_write = 1'b1; core_address = $urandom; core_write_data = $urandom; end
      end
    end
    do_txn(0, 1'b0, 1'b0, $urandom);   // serve the ctrl request still pending

    // Dead memory: timeout, then a late response is ignored.
    mux_selector = 1'b0;
    ctrl_read = 1'b1; ctrl_address = 32'h0000_0BAD;
    do_txn(100, 1'b0, 1'b1, $urandom);
    idle_check(2);

    // Reset two cycles into a core access.
    mux_selector = 1'b1; core_read = 1'b1; core_address = $urandom;
    tick();
    check_value("rst_txn_owner", {31'd0, owner}, 32'd1);
    tick();
    check_value("rst_txn_strobe", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    tick();
    check_value("rst_abort", {28'd0, mem_read, mem_write, busy, core_response}, 32'd0);
    reset = 1'b0; m_last_core = 1'b1;
    ctrl_read = 1'b1; ctrl_address = $urandom;
    do_txn(0, 1'b0, 1'b0, $urandom);
    check_value("after_rst_ctrl_first", {31'd0, owner}, 32'd0);
    do_txn(1, 1'b0, 1'b0, $urandom);

    // mux_selector drops during a core access.
    core_write = 1'b1; core_address = $urandom; core_write_data = $urandom;
    do_txn(2, 1'b1, 1'b0, $urandom);
    core_read = 1'b1; core_address = $urandom;
    ctrl_write = 1'b1; ctrl_address = $urandom; ctrl_write_data = $urandom;
    do_txn(0, 1'b0, 1'b0, $urandom);
    idle_check(3);
    core_read = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      if (!(ctrl_read || ctrl_write) && $urandom_range(0, 9) < 6) begin
        rw = 2'($urandom_range(1, 3));
        ctrl_read = rw[0]; ctrl_write = rw[1];
        ctrl_address = $urandom; ctrl_write_data = $urandom;
      end
      if (!(core_read || core_write) && $urandom_range(0, 9) < 6) begin
        rw = 2'($urandom_range(1, 3));
        core_read = rw[0]; core_write = rw[1];
        core_address = $urandom; core_write_data = $urandom;
      end
      mux_selector = ($urandom_range(0, 9) < 7);
      page_number  = 8'($urandom);
      if (!((ctrl_read || ctrl_write) || (mux_selector && (core_read || core_write))))
        idle_check(1);
      else
        do_txn($urandom_range(0, T + 1), $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) == 1, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
